// File: rtl/ov7670_pkg.sv
// Shared defaults and FSM state type for the OV7670 capture path.
package ov7670_pkg;

  localparam int H_PIXELS_DEF = 320;
  localparam int V_LINES_DEF  = 240;
  localparam int ADDR_W_DEF   = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one camera sync input and flags its rising/falling edges
// against the previous registered value.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      q_prev <= '0;
    end else begin
      q      <= din;
      q_prev <= q;
    end
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: assembles byte pairs into pixels and writes them
// to a linear frame buffer, tracking line/frame boundaries from href/vsync.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              config_finished,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic              line_err,
  output logic [7:0]        frame_cnt
);

  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_PIXELS);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  cap_state_t state, state_nx;

  logic vsync_r, vs_rise, vs_fall;
  logic href_r, hr_rise, hr_fall;
  logic [7:0] d_r, hi_byte;
  logic phase, line_active;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [ADDR_W-1:0] line_base;
  logic start_frame, end_frame, line_end, line_start, byte_en;

  sync_edge_detect u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (vsync),
    .q    (vsync_r),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_detect u_href_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (href),
    .q    (href_r),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r <= '0;
    end else begin
      d_r <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    line_end    = 1'b0;
    line_start  = 1'b0;
    byte_en     = 1'b0;
    if (!config_finished) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_SYNC;
        ST_SYNC: begin
          if (vs_fall) begin
            state_nx    = ST_CAPTURE;
            start_frame = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (vs_rise) begin
            end_frame = 1'b1;
            state_nx  = ST_SYNC;
          end else if (hr_fall && line_active) begin
            line_end = 1'b1;
            if (row == ROW_LAST) begin
              end_frame = 1'b1;
              state_nx  = ST_SYNC;
            end
          // a line only counts if its href rise was seen during active video
          end else if (href_r && !vsync_r && (line_active || hr_rise)) begin
            byte_en    = 1'b1;
            line_start = hr_rise;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      dout        <= '0;
      we          <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_cnt   <= '0;
      hi_byte     <= '0;
      phase       <= 1'b0;
      line_active <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_base   <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= end_frame;
      if (!config_finished) begin
        phase       <= 1'b0;
        line_active <= 1'b0;
        line_err    <= 1'b0;
      end
      if (start_frame) begin
        addr        <= '0;
        col         <= '0;
        row         <= '0;
        phase       <= 1'b0;
        line_base   <= '0;
        line_active <= 1'b0;
      end
      if (end_frame) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      // addr advances in the cycle after the strobe so it is stable while we=1
      if (we) begin
        addr <= addr + 1'b1;
      end
      if (line_start) begin
        line_active <= 1'b1;
      end
      if (line_end) begin
        phase       <= 1'b0;
        col         <= '0;
        row         <= row + 1'b1;
        line_base   <= line_base + LINE_STEP;
        addr        <= line_base + LINE_STEP;
        line_active <= 1'b0;
        if (col != COL_FULL || phase) begin
          line_err <= 1'b1;
        end
      end
      if (byte_en) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= d_r;
        end else if (col != COL_FULL) begin
          dout <= {hi_byte, d_r};
          we   <= 1'b1;
          col  <= col + 1'b1;
        end else begin
          line_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomised bench for ov7670_capture with a line/frame level reference model.
module tb_ov7670_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          config_finished;
  logic          vsync;
  logic          href;
  logic [7:0]    d;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic          we;
  logic          frame_done;
  logic          line_err;
  logic [7:0]    frame_cnt;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .config_finished (config_finished),
    .vsync           (vsync),
    .href            (href),
    .d               (d),
    .addr            (addr),
    .dout            (dout),
    .we              (we),
    .frame_done      (frame_done),
    .line_err        (line_err),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          got_addr[$];
  logic [15:0] got_dout[$];
  int          fd_seen = 0;

  int          exp_addr[$];
  logic [15:0] exp_dout[$];
  int          exp_fd = 0;
  logic [7:0]  exp_fc = '0;
  logic        exp_le = 1'b0;

  logic [7:0] lb [0:7][0:15];
  int         llen [0:7];

  always @(negedge clk) begin
    if (we) begin
      got_addr.push_back(int'(addr));
      got_dout.push_back(dout);
    end
    if (frame_done) fd_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_lines(input int nl, input int len);
    for (int l = 0; l < nl; l++) begin
      llen[l] = len;
      for (int k = 0; k < 16; k++) lb[l][k] = 8'($urandom);
    end
  endtask

  task automatic frame_open();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  // Drives a frame; ab_line/ab_byte raise vsync together with that byte.
  task automatic run_frame(input int nl, input int ab_line, input int ab_byte);
    frame_open();
    for (int l = 0; l < nl; l++) begin
      for (int k = 0; k < llen[l]; k++) begin
        if (l == ab_line && k == ab_byte) vsync = 1'b1;
        href = 1'b1;
        d    = lb[l][k];
        tick();
      end
      href = 1'b0;
      d    = 8'($urandom);
      repeat (3) tick();
      if (l == ab_line) break;
    end
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  // Reference: line l pixel i lands at l*H+i, at most H pixels per line,
  // only the first V lines count, an abort keeps only completed byte pairs.
  task automatic model_frame(input int nl, input int ab_line, input int ab_byte);
    for (int l = 0; l < nl && l < V; l++) begin
      int n;
      int px;
      n = (l == ab_line) ? ab_byte : llen[l];
      px = n / 2;
      if (px > H) px = H;
      for (int i = 0; i < px; i++) begin
        exp_addr.push_back(l * H + i);
        exp_dout.push_back({lb[l][2*i], lb[l][2*i+1]});
      end
      if (l == ab_line) break;
      if (llen[l] != 2 * H) exp_le = 1'b1;
    end
    exp_fd++;
    exp_fc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    config_finished = 1'b1;
    vsync = 1'b1;
    href = 1'b0;
    d = '0;
    repeat (3) tick();
    total++; if (addr !== '0)       begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    total++; if (dout !== '0)       begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
    total++; if (we !== 1'b0)       begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    total++; if (line_err !== 1'b0) begin bad++; $display("FAIL reset_le got=%b exp=0", line_err); end
    total++; if (frame_cnt !== '0)  begin bad++; $display("FAIL reset_fc got=%0d exp=0", frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (we !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL release_pulse got we=%b fd=%b exp 0/0", we, frame_done);
    end
    tick();
  endtask

  task automatic test_full_frame();
    int w0;
    w0 = exp_addr.size();
    for (int l = 0; l < V; l++) begin
      llen[l] = 2 * H;
      for (int k = 0; k < 2 * H; k++) lb[l][k] = 8'h12 + 8'((l * 2 * H + k) * 8'h22);
    end
    run_frame(V, -1, 0);
    model_frame(V, -1, 0);
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL full_nwrites got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end else for (int i = w0; i < exp_addr.size(); i++) begin
      total++; if (got_addr[i] != exp_addr[i] || got_dout[i] !== exp_dout[i]) begin
        bad++; $display("FAIL full_write%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_dout[i], exp_addr[i], exp_dout[i]);
      end
    end
    total++; if (got_dout.size() > w0 && got_dout[w0] !== 16'h1234) begin
      bad++; $display("FAIL full_first_dout got=%h exp=1234", got_dout[w0]);
    end
    total++; if (fd_seen != exp_fd)      begin bad++; $display("FAIL full_fd got=%0d exp=%0d", fd_seen, exp_fd); end
    total++; if (frame_cnt !== exp_fc)   begin bad++; $display("FAIL full_fc got=%0d exp=%0d", frame_cnt, exp_fc); end
    total++; if (line_err !== exp_le)    begin bad++; $display("FAIL full_le got=%b exp=%b", line_err, exp_le); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int w0, nl, abl, abb;
      w0 = exp_addr.size();
      nl = $urandom_range(1, 3);
      fill_lines(nl, 2 * H);
      for (int l = 0; l < nl; l++) if ($urandom_range(0, 1) == 1) llen[l] = $urandom_range(1, 12);
      abl = -1;
      abb = 0;
      if ($urandom_range(0, 3) == 0) begin
        abl = $urandom_range(0, nl - 1);
        abb = $urandom_range(0, llen[abl] - 1);
      end
      run_frame(nl, abl, abb);
      model_frame(nl, abl, abb);
      total++; if (got_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", f, got_addr.size(), exp_addr.size());
      end else for (int i = w0; i < exp_addr.size(); i++) begin
        total++; if (got_addr[i] != exp_addr[i] || got_dout[i] !== exp_dout[i]) begin
          bad++; $display("FAIL rand%0d_write%0d got=%0d/%h exp=%0d/%h", f, i, got_addr[i], got_dout[i], exp_addr[i], exp_dout[i]);
        end
      end
      total++; if (fd_seen != exp_fd)    begin bad++; $display("FAIL rand%0d_fd got=%0d exp=%0d", f, fd_seen, exp_fd); end
      total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL rand%0d_fc got=%0d exp=%0d", f, frame_cnt, exp_fc); end
      total++; if (line_err !== exp_le)  begin bad++; $display("FAIL rand%0d_le got=%b exp=%b", f, line_err, exp_le); end
    end
  endtask

  task automatic clear_err();
    config_finished = 1'b0;
    repeat (2) tick();
    config_finished = 1'b1;
    repeat (2) tick();
    exp_le = 1'b0;
    total++; if (line_err !== 1'b0) begin bad++; $display("FAIL idle_clear_le got=%b exp=0", line_err); end
  endtask

  task automatic test_line_length(input int first_len, input string nm);
    int w0;
    w0 = exp_addr.size();
    fill_lines(V, 2 * H);
    llen[0] = first_len;
    run_frame(V, -1, 0);
    model_frame(V, -1, 0);
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL %s_nwrites got=%0d exp=%0d", nm, got_addr.size(), exp_addr.size());
    end else for (int i = w0; i < exp_addr.size(); i++) begin
      total++; if (got_addr[i] != exp_addr[i] || got_dout[i] !== exp_dout[i]) begin
        bad++; $display("FAIL %s_write%0d got=%0d/%h exp=%0d/%h", nm, i, got_addr[i], got_dout[i], exp_addr[i], exp_dout[i]);
      end
    end
    total++; if (fd_seen != exp_fd)    begin bad++; $display("FAIL %s_fd got=%0d exp=%0d", nm, fd_seen, exp_fd); end
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL %s_fc got=%0d exp=%0d", nm, frame_cnt, exp_fc); end
    total++; if (line_err !== 1'b1)    begin bad++; $display("FAIL %s_le got=%b exp=1", nm, line_err); end
  endtask

  task automatic test_vsync_abort();
    int w0;
    w0 = exp_addr.size();
    fill_lines(V, 2 * H);
    run_frame(V, 1, 3);
    model_frame(V, 1, 3);
    fill_lines(V, 2 * H);
    run_frame(V, -1, 0);
    model_frame(V, -1, 0);
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL abort_nwrites got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end else for (int i = w0; i < exp_addr.size(); i++) begin
      total++; if (got_addr[i] != exp_addr[i] || got_dout[i] !== exp_dout[i]) begin
        bad++; $display("FAIL abort_write%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_dout[i], exp_addr[i], exp_dout[i]);
      end
    end
    total++; if (fd_seen != exp_fd)    begin bad++; $display("FAIL abort_fd got=%0d exp=%0d", fd_seen, exp_fd); end
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL abort_fc got=%0d exp=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_config_drop();
    int w0;
    w0 = exp_addr.size();
    fill_lines(3, 2 * H);
    frame_open();
    for (int k = 0; k < 2 * H; k++) begin href = 1'b1; d = lb[0][k]; tick(); end
    href = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < H; i++) begin
      exp_addr.push_back(i);
      exp_dout.push_back({lb[0][2*i], lb[0][2*i+1]});
    end
    config_finished = 1'b0;
    for (int k = 0; k < 2 * H; k++) begin href = 1'b1; d = lb[1][k]; tick(); end
    href = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 2 * H; k++) begin
      if (k == 2) config_finished = 1'b1;
      href = 1'b1;
      d = lb[2][k];
      tick();
    end
    href = 1'b0;
    repeat (3) tick();
    exp_le = 1'b0;
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL cfg_pre_nwrites got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end
    fill_lines(V, 2 * H);
    run_frame(V, -1, 0);
    model_frame(V, -1, 0);
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL cfg_nwrites got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end else for (int i = w0; i < exp_addr.size(); i++) begin
      total++; if (got_addr[i] != exp_addr[i] || got_dout[i] !== exp_dout[i]) begin
        bad++; $display("FAIL cfg_write%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_dout[i], exp_addr[i], exp_dout[i]);
      end
    end
    total++; if (fd_seen != exp_fd)    begin bad++; $display("FAIL cfg_fd got=%0d exp=%0d", fd_seen, exp_fd); end
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL cfg_fc got=%0d exp=%0d", frame_cnt, exp_fc); end
    total++; if (line_err !== exp_le)  begin bad++; $display("FAIL cfg_le got=%b exp=%b", line_err, exp_le); end
  endtask

  task automatic test_reset_mid_capture();
    int w0;
    w0 = exp_addr.size();
    fill_lines(V, 2 * H);
    frame_open();
    for (int k = 0; k < 2 * H; k++) begin href = 1'b1; d = lb[0][k]; tick(); end
    href = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin href = 1'b1; d = lb[1][k]; tick(); end
    for (int i = 0; i < H; i++) begin
      exp_addr.push_back(i);
      exp_dout.push_back({lb[0][2*i], lb[0][2*i+1]});
    end
    exp_addr.push_back(H);
    exp_dout.push_back({lb[1][0], lb[1][1]});
    rst = 1'b1;
    #1;
    total++; if (addr !== '0 || dout !== '0 || we !== 1'b0 || frame_done !== 1'b0 || line_err !== 1'b0 || frame_cnt !== '0) begin
      bad++; $display("FAIL midrst_outputs got addr=%0d dout=%h we=%b fd=%b le=%b fc=%0d exp all 0", addr, dout, we, frame_done, line_err, frame_cnt);
    end
    exp_fc = '0;
    exp_le = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 5; k < 2 * H; k++) begin href = 1'b1; d = lb[1][k]; tick(); end
    href = 1'b0;
    repeat (3) tick();
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL midrst_pre_nwrites got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end
    fill_lines(V, 2 * H);
    run_frame(V, -1, 0);
    model_frame(V, -1, 0);
    total++; if (got_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL midrst_nwrites got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end else for (int i = w0; i < exp_addr.size(); i++) begin
      total++; if (got_addr[i] != exp_addr[i] || got_dout[i] !== exp_dout[i]) begin
        bad++; $display("FAIL midrst_write%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_dout[i], exp_addr[i], exp_dout[i]);
      end
    end
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL midrst_fc got=%0d exp=%0d", frame_cnt, exp_fc); end
    total++; if (fd_seen != exp_fd)    begin bad++; $display("FAIL midrst_fd got=%0d exp=%0d", fd_seen, exp_fd); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_frames();
    clear_err();
    test_line_length(6, "short");
    clear_err();
    test_line_length(10, "long");
    test_vsync_abort();
    test_config_drop();
    test_reset_mid_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
